// File: rtl/regfile_pkg.sv
// Shared defaults and types for the regfile_sb register file and its scoreboard.
package regfile_pkg;

    localparam int unsigned REGFILE_DATA_W = 8;
    localparam int unsigned REGFILE_ADDR_W = 3;
    localparam int unsigned REGFILE_DEPTH  = 2 ** REGFILE_ADDR_W;
    localparam int unsigned ZERO_REG       = 0;

    typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;
    typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register plus a running count.
// An issue and a clear of the same register in one cycle leave it busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = REGFILE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic             set_eff, inc, dec;

    always_comb begin
        set_eff = set_en && (set_addr != ADDR_W'(ZERO_REG));
        inc     = set_eff && !busy_q[set_addr];
        // A clear that collides with a set on the same register is a no-op.
        dec     = clr_en && busy_q[clr_addr] && !(set_eff && (set_addr == clr_addr));

        busy_d = busy_q;
        if (clr_en)  busy_d[clr_addr] = 1'b0;
        if (set_eff) busy_d[set_addr] = 1'b1;

        cnt_d = cnt_q;
        if (inc && !dec)      cnt_d = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
        else if (dec && !inc) cnt_d = cnt_q - {{ADDR_W{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy1    = busy_q[ra1];
    assign busy2    = busy_q[ra2];
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-write, two-read register file with r0 hardwired to zero and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy clears to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = REGFILE_DATA_W,
    parameter int unsigned ADDR_W = REGFILE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              sb_busy1, sb_busy2;

    // Port 1 is applied last so it wins an address collision with port 0.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        if (we0 && (wa0 != ADDR_W'(ZERO_REG))) mem_d[wa0] = wd0;
        if (we1 && (wa1 != ADDR_W'(ZERO_REG))) mem_d[wa1] = wd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (iss_valid),
        .set_addr (iss_rd),
        .clr_en   (we1),
        .clr_addr (wa1),
        .ra1      (ra1),
        .ra2      (ra2),
        .busy1    (sb_busy1),
        .busy2    (sb_busy2),
        .busy_cnt (busy_cnt)
    );

`ifdef REGFILE_BYPASS_EN
    // Forwarding is gated by rst_n so reads stay zero while reset is held.
    always_comb begin
        rd1 = mem_q[ra1];
        rd2 = mem_q[ra2];
        if (rst_n && (ra1 != ADDR_W'(ZERO_REG))) begin
            if (we1 && (wa1 == ra1))      rd1 = wd1;
            else if (we0 && (wa0 == ra1)) rd1 = wd0;
        end
        if (rst_n && (ra2 != ADDR_W'(ZERO_REG))) begin
            if (we1 && (wa1 == ra2))      rd2 = wd1;
            else if (we0 && (wa0 == ra2)) rd2 = wd0;
        end
        rs1_busy = sb_busy1 && !(we1 && (wa1 == ra1));
        rs2_busy = sb_busy2 && !(we1 && (wa1 == ra2));
    end
`else
    always_comb begin
        rd1      = mem_q[ra1];
        rd2      = mem_q[ra2];
        rs1_busy = sb_busy1;
        rs2_busy = sb_busy2;
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected outputs, a negedge monitor checks them.
module tb_regfile_sb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we0, we1, iss_valid;
    logic [2:0] wa0, wa1, ra1, ra2, iss_rd;
    logic [7:0] wd0, wd1, rd1, rd2;
    logic       rs1_busy, rs2_busy;
    logic [3:0] busy_cnt;

    always #5 clk = ~clk;

    regfile_sb #(
        .DATA_W (8),
        .ADDR_W (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we0       (we0),
        .wa0       (wa0),
        .wd0       (wd0),
        .we1       (we1),
        .wa1       (wa1),
        .wd1       (wd1),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .busy_cnt  (busy_cnt)
    );

    typedef struct {
        logic [7:0] rd1;
        logic [7:0] rd2;
        logic       b1;
        logic       b2;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: plain arrays of register contents and busy flags.
    logic [7:0] m_mem  [8];
    bit         m_busy [8];

    function automatic int popcount_busy();
        int c = 0;
        for (int i = 0; i < 8; i++) c += m_busy[i];
        return c;
    endfunction

    function automatic logic [7:0] model_read(input logic [2:0] ra);
        if (ra == 3'd0) return 8'h00;
`ifdef REGFILE_BYPASS_EN
        if (we1 && wa1 == ra) return wd1;
        if (we0 && wa0 == ra) return wd0;
`endif
        return m_mem[ra];
    endfunction

    function automatic bit model_busy(input logic [2:0] ra);
`ifdef REGFILE_BYPASS_EN
        if (we1 && wa1 == ra) return 1'b0;
`endif
        return m_busy[ra];
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rd1", int'(rd1), int'(e.rd1));
            check("rd2", int'(rd2), int'(e.rd2));
            check("rs1_busy", int'(rs1_busy), int'(e.b1));
            check("rs2_busy", int'(rs2_busy), int'(e.b2));
            check("busy_cnt", int'(busy_cnt), int'(e.cnt));
        end
    end

    task automatic cycle(input bit rst, input bit e0, input logic [2:0] a0, input logic [7:0] d0,
                         input bit e1, input logic [2:0] a1, input logic [7:0] d1,
                         input logic [2:0] r1, input logic [2:0] r2,
                         input bit iv, input logic [2:0] ir);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; we0 = e0; wa0 = a0; wd0 = d0; we1 = e1; wa1 = a1; wd1 = d1;
        ra1 = r1; ra2 = r2; iss_valid = iv; iss_rd = ir;
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin m_mem[i] = 8'h00; m_busy[i] = 1'b0; end
            e.rd1 = 8'h00; e.rd2 = 8'h00; e.b1 = 1'b0; e.b2 = 1'b0; e.cnt = 4'd0;
            exp_q.push_back(e);
        end else begin
            e.rd1 = model_read(r1);
            e.rd2 = model_read(r2);
            e.b1  = model_busy(r1);
            e.b2  = model_busy(r2);
            e.cnt = 4'(popcount_busy());
            exp_q.push_back(e);
            if (e0 && a0 != 3'd0) m_mem[a0] = d0;
            if (e1 && a1 != 3'd0) m_mem[a1] = d1;
            if (e1) m_busy[a1] = 1'b0;
            if (iv && ir != 3'd0) m_busy[ir] = 1'b1;
        end
    endtask

    task automatic idle(input logic [2:0] r1, input logic [2:0] r2);
        cycle(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, r1, r2, 0, 3'd0);
    endtask

    initial begin
        rst_n = 1'b0; we0 = 0; wa0 = 0; wd0 = 0; we1 = 0; wa1 = 0; wd1 = 0;
        ra1 = 0; ra2 = 0; iss_valid = 0; iss_rd = 0;
        for (int i = 0; i < 8; i++) begin m_mem[i] = 8'h00; m_busy[i] = 1'b0; end

        cycle(0, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'd1, 3'd2, 0, 3'd0);
        for (int i = 0; i < 8; i += 2) idle(3'(i), 3'(i + 1));

        // Reset asserted during a write of 0xA5 to r3
        idle(3'd3, 3'd0);
        cycle(1, 1, 3'd3, 8'hA5, 0, 3'd0, 8'h00, 3'd3, 3'd3, 1, 3'd3);
        cycle(0, 1, 3'd3, 8'hA5, 0, 3'd0, 8'h00, 3'd3, 3'd3, 0, 3'd0);
        idle(3'd3, 3'd3);

        // r0 write ignored; port collision on r5
        cycle(1, 1, 3'd0, 8'hFF, 0, 3'd0, 8'h00, 3'd0, 3'd0, 0, 3'd0);
        cycle(1, 1, 3'd5, 8'h3C, 1, 3'd5, 8'h81, 3'd0, 3'd5, 0, 3'd0);
        idle(3'd0, 3'd5);

        // Issue r4, then load writeback clears it
        cycle(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'd4, 3'd0, 1, 3'd4);
        idle(3'd4, 3'd4);
        cycle(1, 0, 3'd0, 8'h00, 1, 3'd4, 8'h77, 3'd4, 3'd4, 0, 3'd0);
        idle(3'd4, 3'd4);

        // Set/clear collision on an already-busy r6
        cycle(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'd6, 3'd0, 1, 3'd6);
        cycle(1, 0, 3'd0, 8'h00, 1, 3'd6, 8'h12, 3'd6, 3'd6, 1, 3'd6);
        idle(3'd6, 3'd6);
        cycle(1, 0, 3'd0, 8'h00, 1, 3'd6, 8'h13, 3'd6, 3'd6, 0, 3'd0);

        // Fill the scoreboard, then drain it in order
        for (int i = 1; i < 8; i++) cycle(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'(i), 3'd0, 1, 3'(i));
        cycle(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'd7, 3'd1, 1, 3'd0);
        for (int i = 1; i < 8; i++) cycle(1, 0, 3'd0, 8'h00, 1, 3'(i), 8'(i * 17), 3'(i), 3'd0, 0, 3'd0);
        idle(3'd7, 3'd1);

        // Same-cycle write and read of r2
        cycle(1, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 3'd0, 3'd0, 1, 3'd2);
        cycle(1, 0, 3'd0, 8'h00, 1, 3'd2, 8'h5A, 3'd2, 3'd2, 0, 3'd0);
        idle(3'd2, 3'd2);
        cycle(1, 1, 3'd2, 8'hC3, 0, 3'd0, 8'h00, 3'd2, 3'd1, 0, 3'd0);
        idle(3'd2, 3'd1);

        for (int n = 0; n < 1500; n++) begin
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 8'($urandom),
                  ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 8'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)));
        end
        idle(3'd0, 3'd0);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
